// File: rtl/fifo_pkg.sv
// Shared helpers for fifo_lanes_sync: pointer width with wrap bit and packed lane layout.
package fifo_pkg;

  function automatic int ptr_w(input int depth_log2);
    return depth_log2 + 1;
  endfunction

  // Lane k of a packed word occupies bits [lane_lsb(k) +: lane_w].
  function automatic int lane_lsb(input int lane, input int lane_w);
    return lane * lane_w;
  endfunction

endpackage

// File: rtl/fifo_lanes_sync_if.sv
// Producer/consumer bundle for fifo_lanes_sync; master drives requests, slave is the FIFO.
interface fifo_lanes_sync_if #(
  parameter int LANES      = 4,
  parameter int LANE_W     = 1,
  parameter int DEPTH_LOG2 = 3
);
  import fifo_pkg::*;

  localparam int W  = LANES * LANE_W;
  localparam int CW = ptr_w(DEPTH_LOG2);

  logic [W-1:0]  din;
  logic          we;
  logic          writable;
  logic          re;
  logic          readable;
  logic [W-1:0]  dout;
  logic          dout_valid;
  logic [CW-1:0] count;
  logic          almost_full;
  logic          flush;
  logic          clr_err;
  logic          overflow;
  logic          underflow;

  modport master (
    output din, we, re, flush, clr_err,
    input  writable, readable, dout, dout_valid, count, almost_full, overflow, underflow
  );

  modport slave (
    input  din, we, re, flush, clr_err,
    output writable, readable, dout, dout_valid, count, almost_full, overflow, underflow
  );

endinterface

// File: rtl/fifo_mem_dp.sv
// Word storage: one synchronous write port, one asynchronous read port, contents not reset.
module fifo_mem_dp #(
  parameter int WIDTH  = 4,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WIDTH-1:0]  o_rdata
);

  logic [WIDTH-1:0] r_mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fifo_lanes_sync.sv
// Single-clock multi-lane FIFO; registered read (1-cycle, dout_valid pulse) or FWFT when FIFO_FWFT_EN is defined.
// writable/readable/almost_full come from registered pointers only; writes when full and reads when empty are dropped and flagged.
module fifo_lanes_sync
  import fifo_pkg::*;
#(
  parameter int LANES      = 4,
  parameter int LANE_W     = 1,
  parameter int DEPTH_LOG2 = 3,
  parameter int AFULL_LVL  = 2**DEPTH_LOG2 - 2
) (
  input  logic              write_clk,
  input  logic              rst_n,
  fifo_lanes_sync_if.slave  bus
);

  localparam int W  = LANES * LANE_W;
  localparam int AW = DEPTH_LOG2;
  localparam int PW = ptr_w(DEPTH_LOG2);
  localparam logic [PW-1:0] AFULL_C = PW'(AFULL_LVL);

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic          r_ovf;
  logic          r_udf;

  logic [PW-1:0] w_count;
  logic          w_full;
  logic          w_empty;
  logic          w_wr_acc;
  logic          w_rd_acc;
  logic          w_ovf_set;
  logic          w_udf_set;
  logic [W-1:0]  w_rd_data;

  // Wrap bit distinguishes full from empty when the address bits match.
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_count = r_wr_ptr - r_rd_ptr;

  assign w_wr_acc  = bus.we && !w_full  && !bus.flush;
  assign w_rd_acc  = bus.re && !w_empty && !bus.flush;
  assign w_ovf_set = bus.we &&  w_full  && !bus.flush;
  assign w_udf_set = bus.re &&  w_empty && !bus.flush;

  fifo_mem_dp #(
    .WIDTH  (W),
    .ADDR_W (AW)
  ) u_mem (
    .clk     (write_clk),
    .i_we    (w_wr_acc),
    .i_waddr (r_wr_ptr[AW-1:0]),
    .i_wdata (bus.din),
    .i_raddr (r_rd_ptr[AW-1:0]),
    .o_rdata (w_rd_data)
  );

  always_ff @(posedge write_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (bus.flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // A new error event outranks clr_err in the same cycle.
  always_ff @(posedge write_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      r_ovf <= w_ovf_set | (r_ovf & ~bus.clr_err);
      r_udf <= w_udf_set | (r_udf & ~bus.clr_err);
    end
  end

`ifdef FIFO_FWFT_EN
  assign bus.dout       = w_empty ? '0 : w_rd_data;
  assign bus.dout_valid = !w_empty;
`else
  logic [W-1:0] r_dout;
  logic         r_dout_vld;

  always_ff @(posedge write_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout     <= '0;
      r_dout_vld <= 1'b0;
    end else begin
      r_dout_vld <= w_rd_acc;
      if (w_rd_acc) r_dout <= w_rd_data;
    end
  end

  assign bus.dout       = r_dout;
  assign bus.dout_valid = r_dout_vld;
`endif

  assign bus.count       = w_count;
  assign bus.writable    = !w_full;
  assign bus.readable    = !w_empty;
  assign bus.almost_full = (w_count >= AFULL_C);
  assign bus.overflow    = r_ovf;
  assign bus.underflow   = r_udf;

endmodule

// File: tb/tb_fifo_lanes_sync.sv
// Randomized scoreboard bench for fifo_lanes_sync against a queue-based reference model.
module tb_fifo_lanes_sync;
  import fifo_pkg::*;

  localparam int LANES      = 4;
  localparam int LANE_W     = 1;
  localparam int DEPTH_LOG2 = 3;
  localparam int DEPTH      = 2**DEPTH_LOG2;
  localparam int AFULL_LVL  = DEPTH - 2;
  localparam int W          = LANES * LANE_W;

  logic write_clk = 1'b0;
  logic rst_n     = 1'b0;

  always #5 write_clk = ~write_clk;

  fifo_lanes_sync_if #(.LANES(LANES), .LANE_W(LANE_W), .DEPTH_LOG2(DEPTH_LOG2)) bus ();

  fifo_lanes_sync #(
    .LANES      (LANES),
    .LANE_W     (LANE_W),
    .DEPTH_LOG2 (DEPTH_LOG2),
    .AFULL_LVL  (AFULL_LVL)
  ) dut (
    .write_clk (write_clk),
    .rst_n     (rst_n),
    .bus       (bus)
  );

  // Reference model: stored words, expected read data, sticky flags.
  logic [W-1:0] mq[$];
  logic [W-1:0] exp_q[$];
  logic         m_ovf = 1'b0;
  logic         m_udf = 1'b0;
  logic [W-1:0] mon_exp;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] lane_word(input int v);
    logic [W-1:0] w;
    w = '0;
    for (int k = 0; k < LANES; k++)
      w[lane_lsb(k, LANE_W) +: LANE_W] = LANE_W'(v >> lane_lsb(k, LANE_W));
    return w;
  endfunction

  task automatic check_status(input string tag);
    chk({tag, "_count"},    32'(bus.count),       32'(mq.size()));
    chk({tag, "_writable"}, 32'(bus.writable),    32'(mq.size() < DEPTH));
    chk({tag, "_readable"}, 32'(bus.readable),    32'(mq.size() > 0));
    chk({tag, "_afull"},    32'(bus.almost_full), 32'(mq.size() >= AFULL_LVL));
    chk({tag, "_ovf"},      32'(bus.overflow),    32'(m_ovf));
    chk({tag, "_udf"},      32'(bus.underflow),   32'(m_udf));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_count"},      32'(bus.count),       32'd0);
    chk({tag, "_writable"},   32'(bus.writable),    32'd1);
    chk({tag, "_readable"},   32'(bus.readable),    32'd0);
    chk({tag, "_dout"},       32'(bus.dout),        32'd0);
    chk({tag, "_dout_valid"}, 32'(bus.dout_valid),  32'd0);
    chk({tag, "_afull"},      32'(bus.almost_full), 32'd0);
    chk({tag, "_ovf"},        32'(bus.overflow),    32'd0);
    chk({tag, "_udf"},        32'(bus.underflow),   32'd0);
  endtask

  // Called just after a rising edge: applies inputs, updates the model for the next edge, then checks flags.
  task automatic cycle(input logic w, input logic [W-1:0] d, input logic r,
                       input logic fl, input logic ce, input string tag);
    bit full, empty;
    bus.we = w; bus.din = d; bus.re = r; bus.flush = fl; bus.clr_err = ce;
    full  = (mq.size() == DEPTH);
    empty = (mq.size() == 0);
    m_ovf = (w && full  && !fl) ? 1'b1 : (ce ? 1'b0 : m_ovf);
    m_udf = (r && empty && !fl) ? 1'b1 : (ce ? 1'b0 : m_udf);
    if (fl) begin
      mq.delete();
    end else begin
      if (r && !empty) exp_q.push_back(mq.pop_front());
      if (w && !full)  mq.push_back(d);
    end
    @(posedge write_clk);
    #1;
    check_status(tag);
  endtask

  always @(negedge write_clk) begin
    if (rst_n) begin
`ifdef FIFO_FWFT_EN
      if (bus.re && bus.readable && !bus.flush) begin
`else
      if (bus.dout_valid) begin
`endif
        if (exp_q.size() == 0) begin
          chk("dout_unexpected", 32'd1, 32'd0);
        end else begin
          mon_exp = exp_q.pop_front();
          chk("dout", 32'(bus.dout), 32'(mon_exp));
        end
      end
    end
  end

  initial begin
    bus.we = 1'b0; bus.re = 1'b0; bus.din = '0; bus.flush = 1'b0; bus.clr_err = 1'b0;
    #12;
    check_reset_outputs("reset");
    @(negedge write_clk);
    rst_n = 1'b1;
    @(posedge write_clk);
    #1;

    for (int i = 1; i <= DEPTH; i++) cycle(1'b1, lane_word(i), 1'b0, 1'b0, 1'b0, "fill");
    cycle(1'b1, lane_word(9), 1'b0, 1'b0, 1'b0, "overflow");
    cycle(1'b1, lane_word(10), 1'b1, 1'b0, 1'b0, "full_wr_rd");
    for (int i = 0; i < DEPTH - 1; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, "drain");
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, "underflow");
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, "clr_err");

    for (int i = 0; i < 20; i++) cycle(1'b1, lane_word(i + 3), 1'b1, 1'b0, 1'b0, "stream");
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, "stream_tail");

    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 99) < 60, W'($urandom), $urandom_range(0, 99) < 55,
            $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 5, "rand");

    while (mq.size() > 0) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, "final_drain");
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, "idle");
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, "idle");
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

    for (int i = 1; i <= 5; i++) cycle(1'b1, lane_word(i), 1'b0, 1'b0, 1'b0, "pre_flush");
    cycle(1'b1, lane_word(15), 1'b0, 1'b1, 1'b0, "flush");

    for (int i = 1; i <= 4; i++) cycle(1'b1, lane_word(i), 1'b0, 1'b0, 1'b0, "pre_rst");
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, "burst");
    bus.re = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    mq.delete();
    exp_q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    bus.re = 1'b0;
    @(negedge write_clk);
    rst_n = 1'b1;
    @(posedge write_clk);
    #1;
    check_status("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
